// File: rtl/aud_pkg.sv
// aud_pkg: shared key indices and per-key debounce state encoding.
package aud_pkg;
  localparam int KEY_STOP = 0;
  localparam int KEY_PLAY = 1;
  localparam int KEY_RECD = 2;
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} key_state_t;
endpackage

// File: rtl/key_conditioner_if.sv
// key_conditioner_if: raw key inputs and conditioned key/command outputs.
interface key_conditioner_if #(parameter int N_KEYS = 3);
  localparam int IDW = N_KEYS > 1 ? $clog2(N_KEYS) : 1;
  logic [N_KEYS-1:0] i_key_raw;
  logic [N_KEYS-1:0] o_level;
  logic [N_KEYS-1:0] o_press;
  logic [N_KEYS-1:0] o_release;
  logic [N_KEYS-1:0] o_long;
  logic              o_cmd_valid;
  logic [IDW-1:0]    o_cmd_id;
  modport master (input i_key_raw, output o_level, o_press, o_release, o_long, o_cmd_valid, o_cmd_id);
  modport slave (output i_key_raw, input o_level, o_press, o_release, o_long, o_cmd_valid, o_cmd_id);
endinterface

// File: rtl/key_debounce_cell.sv
// key_debounce_cell: synchronizes, debounces and times one active-low push button.
module key_debounce_cell
  import aud_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int LONG_CYCLES     = 6000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_raw,
  output logic o_level,
  output logic o_press,
  output logic o_press_next,
  output logic o_release,
  output logic o_long
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] L_MAX  = LW'(LONG_CYCLES);
  logic [1:0]    sync_q;
  key_state_t    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] long_q, long_d, long_inc;
  logic          press_q, release_q, release_d, long_pulse_q, long_pulse_d;
  logic          s;
  assign s        = ~sync_q[1];
  assign long_inc = long_q == L_MAX ? L_MAX : long_q + LW'(1);
  // Hold time keeps accruing through a release bounce so long-press timing is anchored to the press pulse
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    long_d       = long_q;
    o_press_next = 1'b0;
    release_d    = 1'b0;
    case (state_q)
      RELEASED: begin
        state_d = s ? PRESS_WAIT : RELEASED;
        cnt_d   = DW'(s);
        long_d  = '0;
      end
      PRESS_WAIT: begin
        long_d = '0;
        if (!s) state_d = RELEASED;
        else if (cnt_q == D_LAST) begin
          state_d      = PRESSED;
          o_press_next = 1'b1;
        end else cnt_d = cnt_q + DW'(1);
      end
      PRESSED: begin
        long_d = long_inc;
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = DW'(1);
        end
      end
      RELEASE_WAIT: begin
        long_d = long_inc;
        if (s) state_d = PRESSED;
        else if (cnt_q == D_LAST) begin
          state_d   = RELEASED;
          release_d = 1'b1;
        end else cnt_d = cnt_q + DW'(1);
      end
    endcase
    long_pulse_d = (state_d == PRESSED || state_d == RELEASE_WAIT) && long_q != L_MAX && long_d == L_MAX;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q       <= 2'b11;
      state_q      <= RELEASED;
      cnt_q        <= '0;
      long_q       <= '0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_pulse_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], i_key_raw};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      long_q       <= long_d;
      press_q      <= o_press_next;
      release_q    <= release_d;
      long_pulse_q <= long_pulse_d;
    end
  end
  assign o_level   = state_q == PRESSED || state_q == RELEASE_WAIT;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_pulse_q;
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: per-key debounce cells plus a lowest-index-wins press command encoder.
module key_conditioner
  import aud_pkg::*;
#(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int LONG_CYCLES     = 6000000
) (
  input logic               i_clk,
  input logic               i_rst,
  key_conditioner_if.master bus
);
  localparam int IDW = N_KEYS > 1 ? $clog2(N_KEYS) : 1;
  logic [N_KEYS-1:0] level, press, press_next, rel, lng;
  logic [IDW-1:0]    id_d, cmd_id_q;
  logic              cmd_valid_q;
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_cell (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_key_raw   (bus.i_key_raw[k]),
      .o_level     (level[k]),
      .o_press     (press[k]),
      .o_press_next(press_next[k]),
      .o_release   (rel[k]),
      .o_long      (lng[k])
    );
  end
  always_comb begin
    id_d = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) if (press_next[i]) id_d = IDW'(i);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= '0;
    end else begin
      cmd_valid_q <= |press_next;
      cmd_id_q    <= id_d;
    end
  end
  assign bus.o_level     = level;
  assign bus.o_press     = press;
  assign bus.o_release   = rel;
  assign bus.o_long      = lng;
  assign bus.o_cmd_valid = cmd_valid_q;
  assign bus.o_cmd_id    = cmd_id_q;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: scoreboard bench for key_conditioner with short debounce/long timings.
module tb_key_conditioner;
  import aud_pkg::*;
  typedef struct {
    int         cyc;
    logic [2:0] p;
    logic [2:0] r;
    logic [2:0] l;
    logic       cv;
    logic [1:0] id;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   t0  = 0;
  int   total = 0;
  int   bad   = 0;
  ev_t  q[$];
  key_conditioner_if #(.N_KEYS(3)) bus();
  key_conditioner #(.N_KEYS(3), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0h exp=%0h", tag, cyc - t0, got, exp);
    end
  endtask
  task automatic at(input int n);
    while (cyc < t0 + n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input int n, input logic [2:0] p, input logic [2:0] r, input logic [2:0] l,
                      input logic cv, input logic [1:0] id);
    ev_t e;
    e.cyc = t0 + n; e.p = p; e.r = r; e.l = l; e.cv = cv; e.id = id;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    ev_t e;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      chk("missed_event", 32'(cyc), 32'(e.cyc));
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("press", 32'(bus.o_press), 32'(e.p));
      chk("release", 32'(bus.o_release), 32'(e.r));
      chk("long", 32'(bus.o_long), 32'(e.l));
      chk("cmd_valid", 32'(bus.o_cmd_valid), 32'(e.cv));
      chk("cmd_id", 32'(bus.o_cmd_id), 32'(e.id));
    end else if (|{bus.o_press, bus.o_release, bus.o_long, bus.o_cmd_valid, bus.o_cmd_id})
      chk("spurious", 32'({bus.o_press, bus.o_release, bus.o_long, bus.o_cmd_valid, bus.o_cmd_id}), 32'd0);
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    bus.i_key_raw = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    t0  = cyc;
    chk("rst_outputs", 32'({bus.o_level, bus.o_press, bus.o_release, bus.o_long, bus.o_cmd_valid, bus.o_cmd_id}), 32'd0);
    at(10);
    bus.i_key_raw[KEY_PLAY] = 1'b0;
    push(16, 3'b010, 3'b000, 3'b000, 1'b1, 2'd1);
    push(26, 3'b000, 3'b000, 3'b010, 1'b0, 2'd0);
    at(15);
    chk("level_before", 32'(bus.o_level), 32'd0);
    at(16);
    chk("level_pressed", 32'(bus.o_level), 32'b010);
    at(20);
    bus.i_key_raw[KEY_PLAY] = 1'b1;
    at(22);
    bus.i_key_raw[KEY_PLAY] = 1'b0;
    at(25);
    chk("level_bounce", 32'(bus.o_level), 32'b010);
    at(40);
    bus.i_key_raw[KEY_PLAY] = 1'b1;
    push(46, 3'b000, 3'b010, 3'b000, 1'b0, 2'd0);
    at(45);
    chk("level_rel_wait", 32'(bus.o_level), 32'b010);
    at(46);
    chk("level_released", 32'(bus.o_level), 32'd0);
    at(60);
    bus.i_key_raw[KEY_STOP] = 1'b0;
    at(63);
    bus.i_key_raw[KEY_STOP] = 1'b1;
    for (int i = 64; i < 70; i += 2) begin
      at(i);
      chk("glitch_level", 32'(bus.o_level), 32'd0);
    end
    at(70);
    bus.i_key_raw[KEY_RECD] = 1'b0;
    push(76, 3'b100, 3'b000, 3'b000, 1'b1, 2'd2);
    push(86, 3'b000, 3'b000, 3'b100, 1'b0, 2'd0);
    at(100);
    bus.i_key_raw[KEY_RECD] = 1'b1;
    push(106, 3'b000, 3'b100, 3'b000, 1'b0, 2'd0);
    at(120);
    bus.i_key_raw = 3'b010;
    push(126, 3'b101, 3'b000, 3'b000, 1'b1, 2'd0);
    push(136, 3'b000, 3'b000, 3'b101, 1'b0, 2'd0);
    at(130);
    chk("level_dual", 32'(bus.o_level), 32'b101);
    at(150);
    bus.i_key_raw = 3'b111;
    push(156, 3'b000, 3'b101, 3'b000, 1'b0, 2'd0);
    at(170);
    bus.i_key_raw[KEY_PLAY] = 1'b0;
    at(175);
    rst = 1'b1;
    at(176);
    rst = 1'b0;
    chk("midrst_outputs", 32'({bus.o_level, bus.o_press, bus.o_release, bus.o_long, bus.o_cmd_valid, bus.o_cmd_id}), 32'd0);
    push(182, 3'b010, 3'b000, 3'b000, 1'b1, 2'd1);
    push(192, 3'b000, 3'b000, 3'b010, 1'b0, 2'd0);
    at(181);
    chk("level_after_rst", 32'(bus.o_level), 32'd0);
    at(200);
    bus.i_key_raw[KEY_PLAY] = 1'b1;
    push(206, 3'b000, 3'b010, 3'b000, 1'b0, 2'd0);
    at(215);
    chk("drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter N_KEYS, default 3, is the number of push-button channels (0=stop, 1=play, 2=recd).
REQ-002 Parameter DEBOUNCE_CYCLES, default 12000, is the number of consecutive stable samples required to accept a level change (minimum 2).
REQ-003 Parameter LONG_CYCLES, default 6000000, is the number of held cycles after an accepted press before a long-press event (must exceed DEBOUNCE_CYCLES).
REQ-004 i_clk  in  1  the single clock for all logic.
REQ-005 i_rst  in  1  reset; synchronous, active-high.
REQ-006 i_key_raw  in  N_KEYS  raw board buttons, active-low, asynchronous to i_clk.
REQ-007 o_level  out  N_KEYS  debounced level per key, 1 = pressed.
REQ-008 o_press  out  N_KEYS  one-cycle pulse per key on accepted press.
REQ-009 o_release  out  N_KEYS  one-cycle pulse per key on accepted release.
REQ-010 o_long  out  N_KEYS  one-cycle pulse per key when the key has been held LONG_CYCLES past its press pulse.
REQ-011 o_cmd_valid  out  1  one-cycle pulse when at least one o_press bit is set this cycle.
REQ-012 o_cmd_id  out  $clog2(N_KEYS)  index of the lowest-numbered key pressing this cycle; 0 when o_cmd_valid is 0.

Function
REQ-013 Each i_key_raw bit SHALL pass through a 2-flop synchronizer, then be inverted to an active-high sample s.
REQ-014 Each key SHALL run an independent FSM with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-015 RELEASED: s=1 -> PRESS_WAIT, counter=1; otherwise stay, counter=0.
REQ-016 PRESS_WAIT: s=0 -> RELEASED, counter=0; s=1 with counter=DEBOUNCE_CYCLES-1 -> PRESSED; otherwise counter+1.
REQ-017 PRESSED: s=0 -> RELEASE_WAIT, counter=1; s=1 -> long counter increments, saturating at LONG_CYCLES.
REQ-018 RELEASE_WAIT: s=1 -> PRESSED with long counter preserved; s=0 with counter=DEBOUNCE_CYCLES-1 -> RELEASED; otherwise counter+1.
REQ-019 o_press SHALL be registered and high for exactly the one cycle after the PRESS_WAIT->PRESSED transition; with raw held low from cycle t, o_press is high in cycle t+2+DEBOUNCE_CYCLES.
REQ-020 o_release SHALL be high for exactly the one cycle after the RELEASE_WAIT->RELEASED transition.
REQ-021 o_level SHALL be 1 in PRESSED and RELEASE_WAIT, and 0 in RELEASED and PRESS_WAIT.
REQ-022 The long counter SHALL reset to 0 on entry to PRESSED from PRESS_WAIT; o_long SHALL pulse once when it reaches LONG_CYCLES and never again until the next accepted press.
REQ-023 A glitch shorter than DEBOUNCE_CYCLES samples SHALL produce no pulse and no o_level change.
REQ-024 o_cmd_valid/o_cmd_id SHALL be registered in the same cycle as o_press; on simultaneous presses the lowest index wins, and higher-index press pulses still appear on o_press.
REQ-025 Counters SHALL be sized $clog2(LONG_CYCLES+1) (long) and $clog2(DEBOUNCE_CYCLES) (debounce) and SHALL never wrap.

Reset
REQ-026 While i_rst=1, the synchronizer flops SHALL load 1 (released), all FSMs SHALL go to RELEASED, all counters SHALL clear, and every output SHALL be 0 on the next clock edge.
REQ-027 A key held through reset SHALL be treated as a new press, giving o_press DEBOUNCE_CYCLES+2 cycles after reset deassertion; reset mid-debounce SHALL discard the partial count.

Structure
REQ-028 Package aud_pkg SHALL hold KEY_STOP=0, KEY_PLAY=1, KEY_RECD=2 and the 2-bit key_state_t enum.
REQ-029 Per-key logic SHALL be a sub-module key_debounce_cell instantiated N_KEYS times via generate; priority encoding lives in key_conditioner.

Verification (bench parameters DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
REQ-030 Key1 raw low at cycle 10, held -> o_press[1], o_cmd_valid=1 and o_cmd_id=1 at cycle 16 only; o_level[1]=1 from cycle 16.
REQ-031 Key0 raw low for 3 cycles, then high -> no pulses, o_level stays 0.
REQ-032 Key2 held from cycle 10 -> o_press[2] at 16, o_long[2] at 26, no further o_long; release at 40 -> o_release[2] at 46.
REQ-033 Keys 0 and 2 low in the same cycle -> o_press=3'b101, o_cmd_id=0.
REQ-034 Key1 pressed, 2-cycle high bounce inside PRESSED -> no o_release, o_long timing unaffected.
REQ-035 i_rst asserted at the cycle before an expected o_press -> all outputs 0; with key still held, o_press 6 cycles after i_rst falls.
